// File: rtl/lcd_spi_tx_pkg.sv
// Shared types and pin-level constants for the ST7789V3 SPI transmitter.
package lcd_spi_tx_pkg;

    // Transmitter phases: idle, CS/data setup, SCLK high, SCLK low, end-of-word hold
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD
    } state_t;

    // Level driven on the D/CX pin
    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // Maps the upstream is_cmd flag onto the D/CX pin level
    function automatic logic dc_level(input logic is_cmd);
        return is_cmd ? DC_CMD : DC_DATA;
    endfunction

endpackage

// File: rtl/lcd_spi_tx_half_timer.sv
// Half-period down-counter: loads HALF_PERIOD-1 and counts to zero.
// done is high while the count is zero, i.e. in the last cycle of a phase.
module lcd_spi_tx_half_timer #(
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    // A 1-cycle half period still needs a one-bit register
    localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [TW-1:0] tmr_reg;

    // Reload at each phase boundary, otherwise count down and stick at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_reg <= '0;
        end else if (load) begin
            tmr_reg <= TW'(HALF_PERIOD - 1);
        end else if (en && (tmr_reg != '0)) begin
            tmr_reg <= tmr_reg - 1'b1;
        end
    end

    assign done = (tmr_reg == '0);

endmodule

// File: rtl/lcd_spi_tx.sv
// ST7789V3 4-line SPI transmitter: SPI mode 0, MSB first, one word per
// valid/ready accept, chip select held low across back-to-back words.
module lcd_spi_tx
    import lcd_spi_tx_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int HALF_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    output logic                  ready,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic                  is_cmd,
    output logic                  lcd_cs,
    output logic                  lcd_sclk,
    output logic                  lcd_mosi,
    output logic                  lcd_dc,
    output logic                  busy
);

    localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    state_t                state_reg, state_next;
    logic [WORD_WIDTH-1:0] shreg_reg, shreg_next, shreg_shifted;
    logic [CW-1:0]         bit_ctr_reg, bit_ctr_next;
    logic                  cs_reg, cs_next;
    logic                  sclk_reg, sclk_next;
    logic                  mosi_reg, mosi_next;
    logic                  dc_reg, dc_next;
    logic                  tmr_done, tmr_load, tmr_en, accept;

    // Ready only when idle or in the very last hold cycle, so a queued word
    // follows the previous one without releasing chip select
    assign ready  = ~rst & ((state_reg == IDLE) | ((state_reg == HOLD) & tmr_done));
    assign accept = valid & ready;

    // Every timed phase restarts the timer; an accept starts the SETUP phase
    assign tmr_en   = (state_reg != IDLE);
    assign tmr_load = accept | (tmr_en & tmr_done);

    assign shreg_shifted = shreg_reg << 1;

    lcd_spi_tx_half_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(tmr_load),
        .en  (tmr_en),
        .done(tmr_done)
    );

    // State and pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bit_ctr_reg <= '0;
            cs_reg      <= 1'b1;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
            dc_reg      <= DC_CMD;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            bit_ctr_reg <= bit_ctr_next;
            cs_reg      <= cs_next;
            sclk_reg    <= sclk_next;
            mosi_reg    <= mosi_next;
            dc_reg      <= dc_next;
        end
    end

    // Phase sequencing; data only moves on the SCLK falling edge
    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        bit_ctr_next = bit_ctr_reg;
        cs_next      = cs_reg;
        sclk_next    = sclk_reg;
        mosi_next    = mosi_reg;
        dc_next      = dc_reg;

        case (state_reg)
            IDLE: begin
                cs_next   = 1'b1;
                sclk_next = 1'b0;
            end
            SETUP, LOW: begin
                if (tmr_done) begin
                    sclk_next  = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (tmr_done) begin
                    sclk_next = 1'b0;
                    if (bit_ctr_reg == '0) begin
                        state_next = HOLD;
                    end else begin
                        shreg_next   = shreg_shifted;
                        mosi_next    = shreg_shifted[WORD_WIDTH-1];
                        bit_ctr_next = bit_ctr_reg - 1'b1;
                        state_next   = LOW;
                    end
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    cs_next    = 1'b1;
                    mosi_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // An accept (from IDLE or the last HOLD cycle) overrides the above
        if (accept) begin
            shreg_next   = data;
            bit_ctr_next = CW'(WORD_WIDTH - 1);
            dc_next      = dc_level(is_cmd);
            cs_next      = 1'b0;
            sclk_next    = 1'b0;
            mosi_next    = data[WORD_WIDTH-1];
            state_next   = SETUP;
        end
    end

    assign lcd_cs   = cs_reg;
    assign lcd_sclk = sclk_reg;
    assign lcd_mosi = mosi_reg;
    assign lcd_dc   = dc_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Bench for lcd_spi_tx: a negedge monitor records accepts, SCLK rises and
// CS edges; a timing model built from accept times predicts every rise.
module tb_lcd_spi_tx;

    localparam int H      = 2;
    localparam int W      = 8;
    localparam int H2     = 1;
    localparam int W2     = 9;
    localparam int T_WORD = (2 * W + 1) * H;

    typedef struct packed {
        logic [31:0] t;
        logic [8:0]  d;
        logic        c;
    } acc_t;

    typedef struct packed {
        logic [31:0] t;
        logic        mosi;
        logic        dc;
    } rise_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          valid = 1'b0, is_cmd = 1'b0, valid2 = 1'b0, is_cmd2 = 1'b0;
    logic [W-1:0]  data = '0;
    logic [W2-1:0] data2 = '0;
    logic          ready, lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, busy;
    logic          ready2, lcd_cs2, lcd_sclk2, lcd_mosi2, lcd_dc2, busy2;

    lcd_spi_tx #(.WORD_WIDTH(W), .HALF_PERIOD(H)) dut (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready), .data(data),
        .is_cmd(is_cmd), .lcd_cs(lcd_cs), .lcd_sclk(lcd_sclk),
        .lcd_mosi(lcd_mosi), .lcd_dc(lcd_dc), .busy(busy)
    );

    lcd_spi_tx #(.WORD_WIDTH(W2), .HALF_PERIOD(H2)) dut2 (
        .clk(clk), .rst(rst), .valid(valid2), .ready(ready2), .data(data2),
        .is_cmd(is_cmd2), .lcd_cs(lcd_cs2), .lcd_sclk(lcd_sclk2),
        .lcd_mosi(lcd_mosi2), .lcd_dc(lcd_dc2), .busy(busy2)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_bad = 0;
    int chg_bad = 0;

    acc_t  acc_q[$], acc2_q[$];
    rise_t rise_q[$], rise2_q[$], exp_q[$];
    int    cs_rise_q[$], cs_fall_q[$], cs2_rise_q[$], exp_cs_q[$];

    logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0, prev_dc = 1'b0;
    logic prev_sclk2 = 1'b0, prev_cs2 = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: cyc is the number of the edge that just happened
    always @(negedge clk) begin
        if (valid === 1'b1 && ready === 1'b1) acc_q.push_back('{cyc + 1, {1'b0, data}, is_cmd});
        if (lcd_sclk === 1'b1 && prev_sclk !== 1'b1) rise_q.push_back('{cyc, lcd_mosi, lcd_dc});
        if (lcd_cs === 1'b1 && prev_cs === 1'b0) cs_rise_q.push_back(cyc);
        if (lcd_cs === 1'b0 && prev_cs === 1'b1) cs_fall_q.push_back(cyc);
        if (rst === 1'b0 && busy !== ~lcd_cs) busy_bad++;
        if (rst === 1'b0 && prev_sclk === 1'b1 && lcd_sclk === 1'b1 &&
            (lcd_mosi !== prev_mosi || lcd_dc !== prev_dc)) chg_bad++;
        if (valid2 === 1'b1 && ready2 === 1'b1) acc2_q.push_back('{cyc + 1, data2, is_cmd2});
        if (lcd_sclk2 === 1'b1 && prev_sclk2 !== 1'b1) rise2_q.push_back('{cyc, lcd_mosi2, lcd_dc2});
        if (lcd_cs2 === 1'b1 && prev_cs2 === 1'b0) cs2_rise_q.push_back(cyc);
        prev_sclk  = lcd_sclk;
        prev_cs    = lcd_cs;
        prev_mosi  = lcd_mosi;
        prev_dc    = lcd_dc;
        prev_sclk2 = lcd_sclk2;
        prev_cs2   = lcd_cs2;
    end

    // Reference model: k-th rise of a word accepted at t0 is at t0+(2k-1)H
    // carrying bit W-k; CS rises (2W+1)H after the last word of a burst.
    function automatic void build_model();
        exp_q.delete();
        exp_cs_q.delete();
        for (int i = 0; i < acc_q.size(); i++) begin
            for (int k = 1; k <= W; k++)
                exp_q.push_back('{acc_q[i].t + 32'((2 * k - 1) * H), acc_q[i].d[W-k], ~acc_q[i].c});
            if (i == acc_q.size() - 1) exp_cs_q.push_back(int'(acc_q[i].t) + T_WORD);
            else if (int'(acc_q[i+1].t) != int'(acc_q[i].t) + T_WORD) exp_cs_q.push_back(int'(acc_q[i].t) + T_WORD);
        end
    endfunction

    task automatic clear_logs();
        acc_q.delete(); rise_q.delete(); cs_rise_q.delete(); cs_fall_q.delete();
        acc2_q.delete(); rise2_q.delete(); cs2_rise_q.delete();
    endtask

    // Present one word and hold it until accepted; returns at accept edge + 1
    task automatic send(input logic [W-1:0] d, input logic c);
        valid = 1'b1; data = d; is_cmd = c;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
            if (i == 299) begin
                total++; bad++;
                $display("FAIL send_timeout ready=%b required=1", ready);
            end
        end
        @(posedge clk); #1;
        valid = 1'b0; data = 8'($urandom); is_cmd = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && lcd_cs === 1'b1) break;
            if (i == 499) begin
                total++; bad++;
                $display("FAIL idle_timeout busy=%b required=0", busy);
            end
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic compare_model_single_note(); endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, busy, ready} !== 6'b100000) begin
                bad++;
                $display("FAIL reset_hold%0d cs,sclk,mosi,dc,busy,ready=%b required=100000", i,
                         {lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, busy, ready});
            end
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, busy, ready, ready2, lcd_cs2} !== 8'b10000111) begin
            bad++;
            $display("FAIL reset_release cs,sclk,mosi,dc,busy,ready,ready2,cs2=%b required=10000111",
                     {lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, busy, ready, ready2, lcd_cs2});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int s;
        clear_logs();
        s = cyc;
        send(8'h01, 1'b1);
        wait_idle();
        build_model();
        total++;
        if (acc_q.size() != 1 || int'(acc_q[0].t) != s + 1) begin
            bad++;
            $display("FAIL single_accept count=%0d edge=%0d required count=1 edge=%0d",
                     acc_q.size(), acc_q.size() > 0 ? int'(acc_q[0].t) : -1, s + 1);
        end
        total++;
        if (rise_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL single_rise_count got=%0d required=%0d", rise_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rise_q.size(); i++) begin
            total++;
            if (rise_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL single_rise%0d got t=%0d mosi=%b dc=%b required t=%0d mosi=%b dc=%b", i,
                         rise_q[i].t, rise_q[i].mosi, rise_q[i].dc, exp_q[i].t, exp_q[i].mosi, exp_q[i].dc);
            end
        end
        total++;
        if (cs_fall_q.size() != 1 || cs_rise_q.size() != 1 ||
            cs_rise_q[0] - cs_fall_q[0] != T_WORD || cs_rise_q[0] != exp_cs_q[0]) begin
            bad++;
            $display("FAIL single_cs_low falls=%0d rises=%0d low_cycles=%0d required 1 1 %0d",
                     cs_fall_q.size(), cs_rise_q.size(),
                     (cs_fall_q.size() > 0 && cs_rise_q.size() > 0) ? cs_rise_q[0] - cs_fall_q[0] : -1, T_WORD);
        end
        total++;
        if (busy_bad != 0) begin
            bad++;
            $display("FAIL single_busy_vs_cs mismatches=%0d required=0", busy_bad);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send(8'h2A, 1'b1);
        send(8'h00, 1'b0);
        wait_idle();
        build_model();
        total++;
        if (acc_q.size() != 2 || int'(acc_q[1].t) - int'(acc_q[0].t) != T_WORD) begin
            bad++;
            $display("FAIL burst_spacing accepts=%0d gap=%0d required 2 %0d", acc_q.size(),
                     acc_q.size() == 2 ? int'(acc_q[1].t) - int'(acc_q[0].t) : -1, T_WORD);
        end
        total++;
        if (rise_q.size() != 16 || cs_rise_q.size() != 1) begin
            bad++;
            $display("FAIL burst_shape rises=%0d cs_rises=%0d required 16 1", rise_q.size(), cs_rise_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rise_q.size(); i++) begin
            total++;
            if (rise_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL burst_rise%0d got t=%0d mosi=%b dc=%b required t=%0d mosi=%b dc=%b", i,
                         rise_q[i].t, rise_q[i].mosi, rise_q[i].dc, exp_q[i].t, exp_q[i].mosi, exp_q[i].dc);
            end
        end
        total++;
        if (chg_bad != 0) begin
            bad++;
            $display("FAIL burst_change_while_high count=%0d required=0", chg_bad);
        end
    endtask

    task automatic test_backpressure();
        int rdy = 0;
        clear_logs();
        send(8'h96, 1'b0);
        valid = 1'b1; data = 8'h11; is_cmd = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (ready === 1'b1) rdy++;
        end
        @(posedge clk); #1 valid = 1'b0;
        wait_idle();
        build_model();
        total++;
        if (rdy != 1) begin
            bad++;
            $display("FAIL bp_ready_cycles got=%0d required=1", rdy);
        end
        total++;
        if (acc_q.size() != 2 || acc_q[1].d !== 9'h011 || int'(acc_q[1].t) - int'(acc_q[0].t) != T_WORD) begin
            bad++;
            $display("FAIL bp_accepts count=%0d required=2 (second 0x11 at +%0d)", acc_q.size(), T_WORD);
        end
        total++;
        if (rise_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL bp_rise_count got=%0d required=%0d", rise_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rise_q.size(); i++) begin
            total++;
            if (rise_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp_rise%0d got t=%0d mosi=%b required t=%0d mosi=%b", i,
                         rise_q[i].t, rise_q[i].mosi, exp_q[i].t, exp_q[i].mosi);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        send(8'hC3, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rise_q.size() >= 3) break;
        end
        #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if ({lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, busy, ready} !== 6'b100000) begin
            bad++;
            $display("FAIL midreset_outputs cs,sclk,mosi,dc,busy,ready=%b required=100000",
                     {lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, busy, ready});
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        send(8'hA5, 1'b0);
        wait_idle();
        build_model();
        total++;
        if (rise_q.size() != 8 || cs_rise_q.size() != 1) begin
            bad++;
            $display("FAIL midreset_word rises=%0d cs_rises=%0d required 8 1", rise_q.size(), cs_rise_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rise_q.size(); i++) begin
            total++;
            if (rise_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midreset_rise%0d got t=%0d mosi=%b dc=%b required t=%0d mosi=%b dc=%b", i,
                         rise_q[i].t, rise_q[i].mosi, rise_q[i].dc, exp_q[i].t, exp_q[i].mosi, exp_q[i].dc);
            end
        end
    endtask

    task automatic test_random();
        acc_t sent_q[$];
        logic [W-1:0] d;
        logic c;
        clear_logs();
        busy_bad = 0;
        chg_bad = 0;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            c = 1'($urandom);
            sent_q.push_back('{0, {1'b0, d}, c});
            send(d, c);
            if ($urandom_range(0, 2) != 0) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        build_model();
        total++;
        if (acc_q.size() != sent_q.size()) begin
            bad++;
            $display("FAIL rand_accept_count got=%0d required=%0d", acc_q.size(), sent_q.size());
        end
        for (int i = 0; i < sent_q.size() && i < acc_q.size(); i++) begin
            total++;
            if (acc_q[i].d !== sent_q[i].d || acc_q[i].c !== sent_q[i].c) begin
                bad++;
                $display("FAIL rand_accept%0d got d=%h c=%b required d=%h c=%b", i,
                         acc_q[i].d, acc_q[i].c, sent_q[i].d, sent_q[i].c);
            end
        end
        total++;
        if (rise_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_rise_count got=%0d required=%0d", rise_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rise_q.size(); i++) begin
            total++;
            if (rise_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rand_rise%0d got t=%0d mosi=%b dc=%b required t=%0d mosi=%b dc=%b", i,
                         rise_q[i].t, rise_q[i].mosi, rise_q[i].dc, exp_q[i].t, exp_q[i].mosi, exp_q[i].dc);
            end
        end
        total++;
        if (cs_rise_q.size() != exp_cs_q.size()) begin
            bad++;
            $display("FAIL rand_cs_rise_count got=%0d required=%0d", cs_rise_q.size(), exp_cs_q.size());
        end
        for (int i = 0; i < exp_cs_q.size() && i < cs_rise_q.size(); i++) begin
            total++;
            if (cs_rise_q[i] != exp_cs_q[i]) begin
                bad++;
                $display("FAIL rand_cs_rise%0d got=%0d required=%0d", i, cs_rise_q[i], exp_cs_q[i]);
            end
        end
        total++;
        if (busy_bad != 0 || chg_bad != 0) begin
            bad++;
            $display("FAIL rand_pin_rules busy_mismatch=%0d change_while_high=%0d required 0 0", busy_bad, chg_bad);
        end
    endtask

    task automatic test_sweep();
        logic [W2-1:0] d;
        rise_t e;
        int t0;
        for (int w = 0; w < 2; w++) begin
            d = (w == 0) ? 9'h1FF : 9'($urandom);
            clear_logs();
            valid2 = 1'b1; data2 = d; is_cmd2 = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (ready2 === 1'b1) break;
            end
            @(posedge clk); #1 valid2 = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (busy2 === 1'b0) break;
            end
            repeat (2) @(negedge clk);
            t0 = (acc2_q.size() > 0) ? int'(acc2_q[0].t) : 0;
            total++;
            if (acc2_q.size() != 1 || rise2_q.size() != W2) begin
                bad++;
                $display("FAIL sweep%0d_shape accepts=%0d rises=%0d required 1 %0d", w,
                         acc2_q.size(), rise2_q.size(), W2);
            end
            for (int k = 0; k < W2 && k < rise2_q.size(); k++) begin
                e = '{t0 + (2 * k + 1) * H2, d[W2-1-k], 1'b1};
                total++;
                if (rise2_q[k] !== e) begin
                    bad++;
                    $display("FAIL sweep%0d_rise%0d got t=%0d mosi=%b dc=%b required t=%0d mosi=%b dc=1", w, k,
                             rise2_q[k].t, rise2_q[k].mosi, rise2_q[k].dc, e.t, e.mosi);
                end
            end
            total++;
            if (cs2_rise_q.size() != 1 || cs2_rise_q[0] != t0 + (2 * W2 + 1) * H2) begin
                bad++;
                $display("FAIL sweep%0d_cs_rise got=%0d required=%0d", w,
                         cs2_rise_q.size() > 0 ? cs2_rise_q[0] : -1, t0 + (2 * W2 + 1) * H2);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_spi_tx.md
# lcd_spi_tx

Serial transmitter for the ST7789V3 4-line SPI interface. It takes command/data words from the init-sequence decoder, buffered through the command FIFO, using a valid/ready handshake. It shifts each word out MSB-first in SPI mode 0 and drives the panel's chip-select, clock, data and D/CX pins. It is the last stage before the LCD pins.

## Interface
Parameters:
- WORD_WIDTH, 8, bits per transferred word
- HALF_PERIOD, 2, clk cycles per SCLK half-period; legal range 1..255

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; one clock domain (clk)
- valid  in  1  upstream word available
- ready  out  1  block accepts a word this cycle
- data  in  WORD_WIDTH  word to send
- is_cmd  in  1  1 = command byte, 0 = parameter/pixel data
- lcd_cs  out  1  chip select, active-low
- lcd_sclk  out  1  serial clock, idles low
- lcd_mosi  out  1  serial data
- lcd_dc  out  1  D/CX pin: 0 = command, 1 = data
- busy  out  1  high whenever state != IDLE

## Operation
- A word is accepted on any rising clk edge where valid & ready.
- On accept:
  - shreg <= data
  - bit_ctr <= WORD_WIDTH-1
  - lcd_dc <= ~is_cmd
  - lcd_cs <= 0
  - lcd_mosi <= data[MSB]
- State machine, with a half-period timer tmr that counts HALF_PERIOD-1 down to 0:
  - IDLE: cs=1, sclk=0. ready=1. On accept, go to SETUP.
  - SETUP: sclk=0. Lasts HALF_PERIOD cycles (CS/data setup). At tmr==0: sclk<=1, go to HIGH.
  - HIGH: sclk=1, lasts HALF_PERIOD cycles. The panel samples on this phase's rising edge. At tmr==0, sclk<=0, then:
    - if bit_ctr==0, go to HOLD;
    - else shift shreg left, mosi <= next bit, bit_ctr--, go to LOW.
  - LOW: sclk=0, lasts HALF_PERIOD cycles. At tmr==0: sclk<=1, go to HIGH.
  - HOLD: sclk=0, cs=0, lasts HALF_PERIOD cycles. ready=1 only in the final HOLD cycle (tmr==0).
    - Accept in that cycle: go to SETUP with cs held low (back-to-back burst). dc and mosi update on the same edge.
    - No accept: cs<=1, go to IDLE.
- ready = ~rst & (state==IDLE | (state==HOLD & tmr==0)). It is combinational from registered state.
- lcd_dc holds its last value while in IDLE. lcd_mosi returns to 0 on entry to IDLE.
- Upstream must hold data/is_cmd stable while valid & ~ready; the block never samples data outside an accept edge.

## Timing
- Reset values (while rst high and the cycle after): lcd_cs=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, busy=0, ready=0.
  - ready rises combinationally in the first cycle with rst low.
- Let H = HALF_PERIOD, W = WORD_WIDTH, and t0 = the accept edge.
  - lcd_cs falls at t0.
  - First SCLK rise at t0+H.
  - k-th rise (k=1..W) at t0+(2k-1)H.
  - Last fall at t0+2W·H.
  - Next accept possible at edge t0+(2W+1)H.
  - With no further word, lcd_cs rises at t0+(2W+1)H.
- Throughput: one word per (2W+1)H cycles. For defaults, 34 cycles.
- lcd_mosi and lcd_dc change only while lcd_sclk is low, at least H cycles before the next rise.
- rst mid-transfer: all outputs go to reset values on the next edge. The partial word is dropped, not retried.
- valid is ignored in SETUP/HIGH/LOW/HOLD except the final HOLD cycle.

## Structure
- The shared header lcd_st7789v3.vh gains:
  - the state_t typedef (IDLE, SETUP, HIGH, LOW, HOLD);
  - a DC_CMD/DC_DATA pin-level constant.
- One sub-module is natural: spi_half_timer, a down-counter of width $clog2(HALF_PERIOD). Inputs: load, en. Output: a one-cycle done pulse at tmr==0. The FSM, shift register and bit counter stay in lcd_spi_tx.

## Test plan
- Reset: hold rst 3 cycles → cs=1, sclk=0, mosi=0, dc=0, ready=0 throughout; ready=1 in the first cycle after release.
- Single command, data=0x01, is_cmd=1, H=2 → dc=0; mosi sampled at 8 SCLK rises = 0,0,0,0,0,0,0,1; cs low for exactly 34 cycles; busy mirrors cs.
- Burst of 0x2A (cmd) then 0x00 (data), valid held → cs stays low across both words; dc goes 0→1 during low SCLK between words; 16 rises total; second word starts 34 cycles after the first accept.
- Backpressure: valid held high with 0x11 for 50 cycles → exactly one accept; ready high only in IDLE/final HOLD cycle; no duplicate transmission.
- Reset mid-word after 3 SCLK rises → cs=1, sclk=0 on the next edge; a subsequent 0xA5 (data) transmits cleanly as 1,0,1,0,0,1,0,1 with dc=1.
- Parameter sweep H=1, W=9, data=0x1FF → 9 rises at odd cycles 1..17 after accept; cs rises at t0+19.
